// File: rtl/dsp19x2_seq_pkg.sv
// Shared widths, FSM encoding and DSP19X2 control constants for the MAC sequencer.
package dsp19x2_seq_pkg;

  localparam int unsigned A_W   = 10;
  localparam int unsigned B_W   = 9;
  localparam int unsigned Z_W   = 19;
  localparam int unsigned RES_W = 2 * Z_W;

  // DSP19X2 feedback select for plain multiply-accumulate.
  localparam logic [2:0] FEEDBACK_MAC = 3'b000;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [Z_W-1:0] z1;
    logic [Z_W-1:0] z2;
  } res_t;

endpackage

// File: rtl/dsp19x2_seq_res_fifo.sv
// Synchronous result FIFO with combinational head read and occupancy count.
module dsp19x2_seq_res_fifo
  import dsp19x2_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = RES_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // A push into a full buffer is accepted only when the head leaves on the same edge.
  assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/dsp19x2_mac_seq.sv
// Operand sequencer for a DSP19X2 in MULTIPLY_ACCUMULATE mode with a credit-guarded result FIFO.
// Define DSP19X2_SEQ_STATS_EN to enable the frame_count pop counter.
module dsp19x2_mac_seq
  import dsp19x2_seq_pkg::*;
#(
  parameter int unsigned TAPS        = 4,
  parameter int unsigned DSP_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] in_a1,
  input  logic [B_W-1:0] in_b1,
  input  logic [A_W-1:0] in_a2,
  input  logic [B_W-1:0] in_b2,
  output logic [A_W-1:0] A1,
  output logic [B_W-1:0] B1,
  output logic [A_W-1:0] A2,
  output logic [B_W-1:0] B2,
  output logic           LOAD_ACC,
  output logic [2:0]     FEEDBACK,
  input  logic [Z_W-1:0] Z1,
  input  logic [Z_W-1:0] Z2,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [Z_W-1:0] res_z1,
  output logic [Z_W-1:0] res_z2,
  output logic [15:0]    frame_count
);

  localparam int unsigned TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(TAPS - 1);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

  seq_state_e             state_q;
  logic [TAP_W-1:0]       tap_q;
  logic [A_W-1:0]         a1_q;
  logic [B_W-1:0]         b1_q;
  logic [A_W-1:0]         a2_q;
  logic [B_W-1:0]         b2_q;
  logic                   load_q;
  logic                   last_q;
  logic [DSP_LATENCY-1:0] flag_q;
  logic [CNT_W-1:0]       inflight_q;
  logic [CNT_W-1:0]       inflight_d;
  logic [CNT_W-1:0]       occ;
  logic [CNT_W:0]         credit;
  logic                   xfer;
  logic                   is_last;
  logic                   capture;
  logic                   pop;
  logic                   empty;
  res_t                   head;

  assign xfer    = in_valid && in_ready;
  assign is_last = (tap_q == LAST_TAP);
  assign credit  = {1'b0, occ} + {1'b0, inflight_q};
  // A frame may only start if its result slot is guaranteed; once started it never stalls.
  assign in_ready = RESET && ((state_q == ACCUM) || (credit < CREDIT_MAX));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      tap_q   <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      a2_q    <= '0;
      b2_q    <= '0;
      load_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      a1_q   <= xfer ? in_a1 : '0;
      b1_q   <= xfer ? in_b1 : '0;
      a2_q   <= xfer ? in_a2 : '0;
      b2_q   <= xfer ? in_b2 : '0;
      load_q <= xfer && (tap_q == '0);
      last_q <= xfer && is_last;
      if (xfer) begin
        // With TAPS==1 tap 0 is also the last tap, so IDLE loops back onto itself.
        tap_q   <= is_last ? '0 : tap_q + 1'b1;
        state_q <= is_last ? IDLE : ACCUM;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      flag_q <= '0;
    end else begin
      flag_q <= DSP_LATENCY'({flag_q, last_q});
    end
  end

  assign capture = flag_q[DSP_LATENCY-1];

  always_comb begin
    inflight_d = inflight_q;
    case ({xfer && is_last, capture})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  dsp19x2_seq_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W)
  ) u_res_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .push_i  (capture),
    .wdata_i ({Z1, Z2}),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (empty),
    .count_o (occ)
  );

  assign pop       = res_valid && res_ready;
  assign res_valid = !empty;
  assign res_z1    = head.z1;
  assign res_z2    = head.z2;

  assign A1       = a1_q;
  assign B1       = b1_q;
  assign A2       = a2_q;
  assign B2       = b2_q;
  assign LOAD_ACC = load_q;
  assign FEEDBACK = FEEDBACK_MAC;

`ifdef DSP19X2_SEQ_STATS_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      frame_cnt_q <= '0;
    end else if (pop) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_dsp19x2_mac_seq.sv
// Directed bench for dsp19x2_mac_seq with a behavioural DSP19X2 MAC model and result scoreboards.
`timescale 1ns/1ps
module tb_dsp19x2_mac_seq;
  import dsp19x2_seq_pkg::*;

  localparam int unsigned TAPS0 = 4;
  localparam int unsigned LAT0  = 1;
  localparam int unsigned DEP0  = 4;
  localparam int unsigned TAPS1 = 1;
  localparam int unsigned LAT1  = 3;
  localparam int unsigned DEP1  = 8;
`ifdef DSP19X2_SEQ_STATS_EN
  localparam bit          STATS = 1'b1;
  localparam int unsigned BULK  = 65535;
`else
  localparam bit          STATS = 1'b0;
  localparam int unsigned BULK  = 30;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // instance 0: TAPS=4, DSP_LATENCY=1, FIFO_DEPTH=4
  logic rst0, v0, rdy0, ld0, rv0, rr0;
  logic [A_W-1:0] ia1_0, ia2_0, oa1_0, oa2_0;
  logic [B_W-1:0] ib1_0, ib2_0, ob1_0, ob2_0;
  logic [2:0] fb0;
  logic [Z_W-1:0] z1_0, z2_0, rz1_0, rz2_0;
  logic [15:0] fc0;
  // instance 1: TAPS=1, DSP_LATENCY=3, FIFO_DEPTH=8
  logic rst1, v1, rdy1, ld1, rv1, rr1;
  logic [A_W-1:0] ia1_1, ia2_1, oa1_1, oa2_1;
  logic [B_W-1:0] ib1_1, ib2_1, ob1_1, ob2_1;
  logic [2:0] fb1;
  logic [Z_W-1:0] z1_1, z2_1, rz1_1, rz2_1;
  logic [15:0] fc1;

  dsp19x2_mac_seq #(.TAPS(TAPS0), .DSP_LATENCY(LAT0), .FIFO_DEPTH(DEP0)) u_dut0 (
    .CLK(clk), .RESET(rst0), .in_valid(v0), .in_ready(rdy0),
    .in_a1(ia1_0), .in_b1(ib1_0), .in_a2(ia2_0), .in_b2(ib2_0),
    .A1(oa1_0), .B1(ob1_0), .A2(oa2_0), .B2(ob2_0), .LOAD_ACC(ld0), .FEEDBACK(fb0),
    .Z1(z1_0), .Z2(z2_0), .res_valid(rv0), .res_ready(rr0),
    .res_z1(rz1_0), .res_z2(rz2_0), .frame_count(fc0));

  dsp19x2_mac_seq #(.TAPS(TAPS1), .DSP_LATENCY(LAT1), .FIFO_DEPTH(DEP1)) u_dut1 (
    .CLK(clk), .RESET(rst1), .in_valid(v1), .in_ready(rdy1),
    .in_a1(ia1_1), .in_b1(ib1_1), .in_a2(ia2_1), .in_b2(ib2_1),
    .A1(oa1_1), .B1(ob1_1), .A2(oa2_1), .B2(ob2_1), .LOAD_ACC(ld1), .FEEDBACK(fb1),
    .Z1(z1_1), .Z2(z2_1), .res_valid(rv1), .res_ready(rr1),
    .res_z1(rz1_1), .res_z2(rz2_1), .frame_count(fc1));

  function automatic logic [Z_W-1:0] mul19(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    int pa, pb;
    pa = $signed(a);
    pb = $signed(b);
    return Z_W'(pa * pb);
  endfunction

  // DSP19X2 MAC model: accumulator register plus DSP_LATENCY-1 output stages.
  logic [Z_W-1:0] zp1_0 [LAT0];
  logic [Z_W-1:0] zp2_0 [LAT0];
  logic [Z_W-1:0] zp1_1 [LAT1];
  logic [Z_W-1:0] zp2_1 [LAT1];

  always @(posedge clk) begin
    zp1_0[0] <= ld0 ? mul19(oa1_0, ob1_0) : zp1_0[0] + mul19(oa1_0, ob1_0);
    zp2_0[0] <= ld0 ? mul19(oa2_0, ob2_0) : zp2_0[0] + mul19(oa2_0, ob2_0);
    for (int i = LAT0 - 1; i > 0; i--) begin
      zp1_0[i] <= zp1_0[i-1];
      zp2_0[i] <= zp2_0[i-1];
    end
    zp1_1[0] <= ld1 ? mul19(oa1_1, ob1_1) : zp1_1[0] + mul19(oa1_1, ob1_1);
    zp2_1[0] <= ld1 ? mul19(oa2_1, ob2_1) : zp2_1[0] + mul19(oa2_1, ob2_1);
    for (int i = LAT1 - 1; i > 0; i--) begin
      zp1_1[i] <= zp1_1[i-1];
      zp2_1[i] <= zp2_1[i-1];
    end
  end

  assign z1_0 = zp1_0[LAT0-1];
  assign z2_0 = zp2_0[LAT0-1];
  assign z1_1 = zp1_1[LAT1-1];
  assign z2_1 = zp2_1[LAT1-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [RES_W-1:0] sb0[$];
  logic [RES_W-1:0] sb1[$];
  int pops0 = 0;
  int pops1 = 0;

  // Pops are decided at the next rising edge; all inputs are stable by the falling edge.
  always @(negedge clk) begin
    if (rst0 && rv0 && rr0) begin
      chk("fc0", 64'(fc0), STATS ? 64'(16'(pops0)) : 64'd0);
      chk("res0_avail", 64'(sb0.size() != 0), 64'd1);
      if (sb0.size() != 0) chk("res0", 64'({rz1_0, rz2_0}), 64'(sb0.pop_front()));
      pops0++;
    end
    if (rst1 && rv1 && rr1) begin
      chk("fc1", 64'(fc1), STATS ? 64'(16'(pops1)) : 64'd0);
      chk("res1_avail", 64'(sb1.size() != 0), 64'd1);
      if (sb1.size() != 0) chk("res1", 64'({rz1_1, rz2_1}), 64'(sb1.pop_front()));
      pops1++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    v0 = 1'b0; ia1_0 = '0; ib1_0 = '0; ia2_0 = '0; ib2_0 = '0;
  endtask

  task automatic idle1();
    v1 = 1'b0; ia1_1 = '0; ib1_1 = '0; ia2_1 = '0; ib2_1 = '0;
  endtask

  task automatic op0(input logic [A_W-1:0] a1, input logic [B_W-1:0] b1,
                     input logic [A_W-1:0] a2, input logic [B_W-1:0] b2);
    int n = 0;
    v0 = 1'b1; ia1_0 = a1; ib1_0 = b1; ia2_0 = a2; ib2_0 = b2;
    while (!rdy0 && n < 200) begin tick(); n++; end
    chk("op0_ready", 64'(rdy0), 64'd1);
    tick();
  endtask

  task automatic op1(input logic [A_W-1:0] a1, input logic [B_W-1:0] b1,
                     input logic [A_W-1:0] a2, input logic [B_W-1:0] b2);
    int n = 0;
    v1 = 1'b1; ia1_1 = a1; ib1_1 = b1; ia2_1 = a2; ib2_1 = b2;
    while (!rdy1 && n < 200) begin tick(); n++; end
    chk("op1_ready", 64'(rdy1), 64'd1);
    tick();
    sb1.push_back({mul19(a1, b1), mul19(a2, b2)});
  endtask

  // Sends ntaps operands of a frame (a1 = base+k, b1 = 2); a full frame queues its expected result.
  task automatic frame0(input int base, input int ntaps, input int gap_after, input int gap_len);
    logic [Z_W-1:0] s1, s2;
    logic [A_W-1:0] a1, a2;
    logic [B_W-1:0] b1, b2;
    s1 = '0; s2 = '0;
    for (int k = 0; k < ntaps; k++) begin
      a1 = A_W'(base + k);
      b1 = B_W'(2);
      a2 = A_W'(k * 37 - base * 5);
      b2 = B_W'(7 - 3 * k);
      if (k > 0) chk("ready_in_accum", 64'(rdy0), 64'd1);
      op0(a1, b1, a2, b2);
      s1 = s1 + mul19(a1, b1);
      s2 = s2 + mul19(a2, b2);
      chk("A1_tap", 64'(oa1_0), 64'(a1));
      chk("B2_tap", 64'(ob2_0), 64'(b2));
      chk("LOAD_tap", 64'(ld0), 64'(k == 0));
      if (k == TAPS0 - 1) sb0.push_back({s1, s2});
      if (k == gap_after) begin
        idle0();
        for (int g = 0; g < gap_len; g++) begin
          tick();
          chk("gap_AB", 64'({oa1_0, ob1_0, oa2_0, ob2_0}), 64'd0);
          chk("gap_LOAD", 64'(ld0), 64'd0);
        end
      end
    end
  endtask

  task automatic drain0();
    int n = 0;
    while ((sb0.size() != 0 || rv0) && n < 300) begin tick(); n++; end
    chk("drain0_sb", 64'(sb0.size()), 64'd0);
    chk("drain0_rv", 64'(rv0), 64'd0);
  endtask

  task automatic drain1();
    int n = 0;
    while ((sb1.size() != 0 || rv1) && n < 300) begin tick(); n++; end
    chk("drain1_sb", 64'(sb1.size()), 64'd0);
    chk("drain1_rv", 64'(rv1), 64'd0);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int frames1;
    rst0 = 1'b0; rst1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    idle0(); idle1();
    repeat (3) tick();
    chk("rst_ready0", 64'(rdy0), 64'd0);
    chk("rst_AB0", 64'({oa1_0, ob1_0, oa2_0, ob2_0}), 64'd0);
    chk("rst_LOAD0", 64'(ld0), 64'd0);
    chk("rst_rv0", 64'(rv0), 64'd0);
    chk("rst_fb0", 64'(fb0), 64'd0);
    chk("rst_fc0", 64'(fc0), 64'd0);
    chk("rst_ready1", 64'(rdy1), 64'd0);
    chk("rst_rv1", 64'(rv1), 64'd0);
    rst0 = 1'b1; rst1 = 1'b1;
    tick();
    chk("ready0_after_rst", 64'(rdy0), 64'd1);
    chk("ready1_after_rst", 64'(rdy1), 64'd1);

    // a1=1..4, b1=2 with no stalls: result 20, pushed one cycle after the last operand
    frame0(1, 4, -1, 0);
    idle0();
    tick();
    chk("lat_rv_early", 64'(rv0), 64'd0);
    tick();
    chk("lat_rv", 64'(rv0), 64'd1);
    chk("lat_z1", 64'(rz1_0), 64'd20);
    chk("fb0_run", 64'(fb0), 64'd0);
    rr0 = 1'b1;
    drain0();

    // same frame with a 3-cycle in_valid gap: bubbles add zero
    frame0(1, 4, 1, 3);
    idle0();
    drain0();

    // backpressure: four frames fill the credit, fifth tap 0 must wait
    rr0 = 1'b0;
    for (int f = 0; f < 4; f++) frame0(10 + 10 * f, 4, -1, 0);
    chk("full_ready", 64'(rdy0), 64'd0);
    v0 = 1'b1; ia1_0 = 10'd50; ib1_0 = 9'd2;
    repeat (4) tick();
    chk("full_ready_hold", 64'(rdy0), 64'd0);
    chk("full_no_xfer", 64'(oa1_0), 64'd0);
    chk("full_rv", 64'(rv0), 64'd1);
    rr0 = 1'b1;
    frame0(50, 4, -1, 0);
    frame0(60, 4, -1, 0);
    idle0();
    drain0();

    // reset in the middle of a frame discards it
    frame0(80, 2, -1, 0);
    v0 = 1'b1; ia1_0 = 10'd82; ib1_0 = 9'd2;
    rst0 = 1'b0;
    pops0 = 0;
    tick();
    chk("mid_rst_ready", 64'(rdy0), 64'd0);
    chk("mid_rst_AB", 64'({oa1_0, ob1_0, oa2_0, ob2_0}), 64'd0);
    chk("mid_rst_LOAD", 64'(ld0), 64'd0);
    rst0 = 1'b1;
    idle0();
    repeat (8) tick();
    chk("mid_rst_no_res", 64'(rv0), 64'd0);
    frame0(90, 4, -1, 0);
    idle0();
    drain0();

    // TAPS=1, DSP_LATENCY=3: a2=-512, b2=255 -> -130560 on res_z2
    op1(10'd5, 9'h1FD, 10'h200, 9'h0FF);
    chk("t1_LOAD", 64'(ld1), 64'd1);
    chk("t1_A2", 64'(oa2_1), 64'h200);
    idle1();
    repeat (3) tick();
    chk("t1_rv_early", 64'(rv1), 64'd0);
    tick();
    chk("t1_rv", 64'(rv1), 64'd1);
    chk("t1_z2", 64'(rz2_1), 64'h60200);
    chk("t1_z1", 64'(rz1_1), 64'h7FFF1);
    rr1 = 1'b1;
    op1(10'h3FF, 9'h100, 10'd511, 9'h0FF);
    chk("t1_LOAD2", 64'(ld1), 64'd1);
    chk("fb1_run", 64'(fb1), 64'd0);
    idle1();
    drain1();

    // bulk single-tap frames exercising pointer and frame_count wrap
    for (int i = 0; i < BULK; i++) begin
      op1(A_W'($urandom), B_W'($urandom), A_W'($urandom), B_W'($urandom));
    end
    idle1();
    drain1();
    frames1 = 2 + BULK;
    chk("fc1_final", 64'(fc1), STATS ? 64'(16'(frames1)) : 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dsp19x2_mac_seq.md
DSP19X2_MAC_SEQ -- requirements
Module: dsp19x2_mac_seq

Interface
REQ-001 SHALL have parameter TAPS, default 4: operand pairs per frame (1..32).
REQ-002 SHALL have parameter DSP_LATENCY, default 1: cycles from an operand driven on A/B to its accumulated value on Z (1..3).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: result buffer entries (power of 2, 2..16).
REQ-004 SHALL have ports: CLK in 1 clock; RESET in 1, synchronous active-low reset.
REQ-005 SHALL have ports: in_valid in 1, in_ready out 1; in_a1 in 10, in_b1 in 9, in_a2 in 10, in_b2 in 9 (operand stream).
REQ-006 SHALL have ports: A1 out 10, B1 out 9, A2 out 10, B2 out 9, LOAD_ACC out 1, FEEDBACK out 3 (to DSP19X2 in MULTIPLY_ACCUMULATE mode).
REQ-007 SHALL have ports: Z1 in 19, Z2 in 19 (from DSP19X2).
REQ-008 SHALL have ports: res_valid out 1, res_ready in 1, res_z1 out 19, res_z2 out 19 (result stream); frame_count out 16.

Function
REQ-009 SHALL transfer an operand when in_valid && in_ready at a rising CLK edge.
REQ-010 SHALL register transferred operands onto A1/B1/A2/B2 one cycle after transfer.
REQ-011 SHALL drive A1/B1/A2/B2 to 0 in every cycle without a transfer, so bubbles add zero.
REQ-012 SHALL count taps 0..TAPS-1 and assert LOAD_ACC, registered with the operands, for tap 0 only.
REQ-013 SHALL drive FEEDBACK to 3'b000 at all times.
REQ-014 SHALL use FSM IDLE -> ACCUM on a tap-0 transfer, and ACCUM -> IDLE on a tap TAPS-1 transfer.
REQ-015 SHALL go IDLE -> IDLE when TAPS==1 and each transfer is a full frame.
REQ-016 SHALL keep the tap counter unchanged during in_valid gaps in ACCUM, with no timeout.
REQ-017 SHALL pass the last-tap flag through a DSP_LATENCY-stage delay line after the operand register.
REQ-018 SHALL capture Z1/Z2 into the result FIFO when that flag emerges.
REQ-019 SHALL track credit = FIFO occupancy + frames in flight (last tap transferred, result not yet captured).
REQ-020 SHALL deassert in_ready in IDLE when credit == FIFO_DEPTH.
REQ-021 SHALL never deassert in_ready within ACCUM.
REQ-022 SHALL reserve credit at the last-tap transfer and release it on a FIFO pop, so the FIFO never overflows.
REQ-023 SHALL present the FIFO head on res_z1/res_z2 with res_valid = not empty.
REQ-024 SHALL pop on res_valid && res_ready; a simultaneous capture and pop leaves occupancy unchanged.
REQ-025 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.
REQ-026 SHALL hold res_z1/res_z2 stable while res_valid && !res_ready.

Reset
REQ-027 SHALL, with RESET low at a CLK edge, clear FSM to IDLE, tap counter, delay line, FIFO, credit and frame_count.
REQ-028 SHALL hold in reset: A/B = 0, LOAD_ACC = 0, res_valid = 0, in_ready = 0; in_ready = 1 the first cycle after release.
REQ-029 SHALL discard partial and in-flight frames when reset occurs mid-frame, and emit no result for them.

Configuration
REQ-030 SHALL, with DSP19X2_SEQ_STATS_EN defined, increment frame_count on each pop, wrapping 16'hFFFF -> 0.
REQ-031 SHALL, without DSP19X2_SEQ_STATS_EN, tie frame_count to 0 and implement no counter logic.

Structure
REQ-032 SHALL define in package dsp19x2_seq_pkg: the A/B/Z width constants, FSM state enum {IDLE, ACCUM}, and the FEEDBACK constant.
REQ-033 SHALL place the result buffer in sub-module dsp19x2_seq_res_fifo (38-bit entries, FIFO_DEPTH deep, synchronous, count output).

Verification
REQ-034 SHALL cover: TAPS=4, DSP_LATENCY=1, operand pairs a1=1..4 with b1=2, no stalls -> LOAD_ACC high for tap 0 only; one res_z1=20 pushed 1 cycle after the 4th operand reaches A1.
REQ-035 SHALL cover: same frame with in_valid low 3 cycles between taps 2 and 3 -> A/B = 0 during the gap; result still 20; exactly one push.
REQ-036 SHALL cover: res_ready held 0, 6 back-to-back frames, FIFO_DEPTH=4 -> in_ready low in IDLE after 4th frame's last tap; no overflow; then res_ready=1 -> 4 results in order, then frames 5-6.
REQ-037 SHALL cover: RESET low during tap 2 of a frame -> no result emitted; next full frame result correct with LOAD_ACC on its first tap.
REQ-038 SHALL cover: TAPS=1, DSP_LATENCY=3, signed a2=-512 with b2=255 -> LOAD_ACC every transfer; res_z2=-130560 three cycles after operand drive.
REQ-039 SHALL cover: DSP19X2_SEQ_STATS_EN defined, 65537 pops -> frame_count=1; undefined -> frame_count=0 throughout.
